// File: rtl/vm_write_scheduler_pkg.sv
// Shared widths, console control codes and scheduler state encoding for the
// video-memory port-A write scheduler.
package vm_write_scheduler_pkg;

  localparam int VM_ADDR_W = 12;
  localparam int VM_DATA_W = 8;
  localparam int ROW_W     = 5;
  localparam int COL_W     = 5;

  localparam logic [VM_DATA_W-1:0] CH_LF = 8'h0A;
  localparam logic [VM_DATA_W-1:0] CH_CR = 8'h0D;
  localparam logic [VM_DATA_W-1:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_e;

  // Text cell to port-A address; the top two address bits are never used.
  function automatic logic [VM_ADDR_W-1:0] vm_addr_of(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
    return {2'b00, row, col};
  endfunction

endpackage

// File: rtl/vm_fill_sequencer.sv
// Row/column sweep counter used by both clear states. A start pulse loads the
// sweep; from the next cycle addr walks one cell per clock, either across a
// single row or over the whole ROWSxCOLS screen in row-major order. done is
// high during the last cell of the sweep.
module vm_fill_sequencer
  import vm_write_scheduler_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 32
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 full,
  input  logic [ROW_W-1:0]     start_row,
  output logic [VM_ADDR_W-1:0] addr,
  output logic                 active,
  output logic                 done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             full_q, full_d;
  logic             active_q, active_d;
  logic             last_cell;

  // Final cell: end of the row, and either a one-row sweep or the last row.
  assign last_cell = (col_q == LAST_COL) && (!full_q || (row_q == LAST_ROW));

  // Next sweep position; counters wrap at COLS/ROWS, not at the power of two.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    full_d   = full_q;
    active_d = active_q;
    if (start) begin
      row_d    = full ? '0 : start_row;
      col_d    = '0;
      full_d   = full;
      active_d = 1'b1;
    end else if (active_q) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (last_cell) active_d = 1'b0;
        else           row_d    = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      col_q    <= '0;
      full_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      full_q   <= full_d;
      active_q <= active_d;
    end
  end

  assign addr   = vm_addr_of(row_q, col_q);
  assign active = active_q;
  assign done   = active_q && last_cell;

endmodule

// File: rtl/vm_write_scheduler.sv
// Sole owner of video-memory write port A. One write per clock, priority
// screen clear > direct CPU write > console character. The console path keeps
// the text cursor, handles LF/CR/BS, and blanks every newly entered line.
module vm_write_scheduler
  import vm_write_scheduler_pkg::*;
#(
  parameter int                   COLS           = 32,
  parameter int                   ROWS           = 30,
  parameter logic [VM_DATA_W-1:0] FILL_CHAR      = 8'h20,
  parameter bit                   CLEAR_ON_RESET = 1'b0
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  input  logic [VM_DATA_W-1:0] ch_data,
  input  logic                 ch_valid,
  output logic                 ch_ready,
  input  logic                 cpu_we,
  input  logic [VM_ADDR_W-1:0] cpu_addr,
  input  logic [VM_DATA_W-1:0] cpu_din,
  output logic                 cpu_ack,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 vm_we,
  output logic [VM_ADDR_W-1:0] vm_addr,
  output logic [VM_DATA_W-1:0] vm_din,
  output logic [ROW_W-1:0]     cur_row,
  output logic [COL_W-1:0]     cur_col
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 boot_q, boot_d;
  logic                 vm_we_q, vm_we_d;
  logic [VM_ADDR_W-1:0] vm_addr_q, vm_addr_d;
  logic [VM_DATA_W-1:0] vm_din_q, vm_din_d;
  logic                 cpu_ack_q, cpu_ack_d;

  logic                 seq_start, seq_full, seq_active, seq_done;
  logic [ROW_W-1:0]     seq_row, nl_row;
  logic [VM_ADDR_W-1:0] seq_addr;
  logic                 cpu_take;

  vm_fill_sequencer #(.ROWS(ROWS), .COLS(COLS)) u_fill (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .start     (seq_start),
    .full      (seq_full),
    .start_row (seq_row),
    .addr      (seq_addr),
    .active    (seq_active),
    .done      (seq_done)
  );

  // Row the cursor enters on a newline, wrapping after the last text row.
  assign nl_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  // The requester still holds cpu_we during its ack cycle; don't write twice.
  assign cpu_take = cpu_we && !cpu_ack_q;

  // boot_q only exists when CLEAR_ON_RESET is set and behaves as a pending clear.
  assign ch_ready = (state_q == IDLE) && !clr_pend_q && !boot_q && !cpu_we && !rst;

  // Arbitration, cursor update and next port-A write.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    clr_pend_d = clr_pend_q;
    boot_d     = boot_q;
    vm_we_d    = 1'b0;
    vm_addr_d  = vm_addr_q;
    vm_din_d   = vm_din_q;
    cpu_ack_d  = 1'b0;
    seq_start  = 1'b0;
    seq_full   = 1'b0;
    seq_row    = row_q;

    // A clear request during a running full clear is redundant and dropped.
    if (clr_req && (state_q != CLR_ALL)) clr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (clr_pend_q || boot_q) begin
          state_d   = CLR_ALL;
          seq_start = 1'b1;
          seq_full  = 1'b1;
          boot_d    = 1'b0;
        end else if (cpu_take) begin
          vm_we_d   = 1'b1;
          vm_addr_d = cpu_addr;
          vm_din_d  = cpu_din;
          cpu_ack_d = 1'b1;
        end else if (ch_valid && ch_ready) begin
          case (ch_data)
            CH_LF: begin
              col_d     = '0;
              row_d     = nl_row;
              state_d   = CLR_LINE;
              seq_start = 1'b1;
              seq_row   = nl_row;
            end
            CH_CR: col_d = '0;
            CH_BS: begin
              if (col_q != '0) begin
                col_d     = col_q - 1'b1;
                vm_we_d   = 1'b1;
                vm_addr_d = vm_addr_of(row_q, col_d);
                vm_din_d  = FILL_CHAR;
              end
            end
            default: begin
              vm_we_d   = 1'b1;
              vm_addr_d = vm_addr_of(row_q, col_q);
              vm_din_d  = ch_data;
              if (col_q == LAST_COL) begin
                col_d     = '0;
                row_d     = nl_row;
                state_d   = CLR_LINE;
                seq_start = 1'b1;
                seq_row   = nl_row;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          endcase
        end
      end
      CLR_LINE: begin
        vm_we_d   = seq_active;
        vm_addr_d = seq_addr;
        vm_din_d  = FILL_CHAR;
        if (seq_done) state_d = IDLE;
      end
      CLR_ALL: begin
        vm_we_d   = seq_active;
        vm_addr_d = seq_addr;
        vm_din_d  = FILL_CHAR;
        if (seq_done) begin
          state_d    = IDLE;
          row_d      = '0;
          col_d      = '0;
          clr_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and registered port-A outputs.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      clr_pend_q <= 1'b0;
      boot_q     <= CLEAR_ON_RESET;
      vm_we_q    <= 1'b0;
      vm_addr_q  <= '0;
      vm_din_q   <= '0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      clr_pend_q <= clr_pend_d;
      boot_q     <= boot_d;
      vm_we_q    <= vm_we_d;
      vm_addr_q  <= vm_addr_d;
      vm_din_q   <= vm_din_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  assign busy    = (state_q != IDLE) || clr_pend_q;
  assign vm_we   = vm_we_q;
  assign vm_addr = vm_addr_q;
  assign vm_din  = vm_din_q;
  assign cpu_ack = cpu_ack_q;
  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule

// File: tb/tb_vm_write_scheduler.sv
// Bench for vm_write_scheduler: directed steps plus a random console stream,
// checked against a text-screen model (cursor + expected memory image).
module tb_vm_write_scheduler;
  localparam int COLS = 32;
  localparam int ROWS = 30;

  logic        clk_50mhz = 1'b0;
  logic        rst, rst2;
  logic [7:0]  ch_data;
  logic        ch_valid, ch_ready;
  logic        cpu_we, cpu_ack;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        clr_req, busy, vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_din;
  logic [4:0]  cur_row, cur_col;

  logic        ch_ready2, cpu_ack2, busy2, vm_we2;
  logic [11:0] vm_addr2;
  logic [7:0]  vm_din2;
  logic [4:0]  cur_row2, cur_col2;

  vm_write_scheduler dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .clr_req(clr_req), .busy(busy), .vm_we(vm_we),
    .vm_addr(vm_addr), .vm_din(vm_din), .cur_row(cur_row), .cur_col(cur_col)
  );

  vm_write_scheduler #(.CLEAR_ON_RESET(1'b1)) dut2 (
    .clk_50mhz(clk_50mhz), .rst(rst2), .ch_data(8'h00), .ch_valid(1'b0),
    .ch_ready(ch_ready2), .cpu_we(1'b0), .cpu_addr(12'h000), .cpu_din(8'h00),
    .cpu_ack(cpu_ack2), .clr_req(1'b0), .busy(busy2), .vm_we(vm_we2),
    .vm_addr(vm_addr2), .vm_din(vm_din2), .cur_row(cur_row2), .cur_col(cur_col2)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int         total = 0;
  int         bad   = 0;
  int         wr_cnt = 0;
  int         wr_cnt2 = 0;
  logic [7:0] shadow  [4096];
  logic [7:0] exp_mem [4096];
  int         m_row, m_col, exp_w;
  logic       w_we;
  logic [11:0] w_addr;
  logic [7:0]  w_din;

  // Memory seen by port A: every registered write lands at the next edge.
  always @(posedge clk_50mhz) begin
    if (vm_we === 1'b1) begin
      shadow[vm_addr] = vm_din;
      wr_cnt++;
    end
    if (vm_we2 === 1'b1) wr_cnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Screen model: cursor moves, newline blanks the entered row.
  task automatic m_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) exp_mem[m_row*32 + c] = 8'h20;
    exp_w += COLS;
  endtask

  task automatic m_char(input logic [7:0] c);
    if (c == 8'h0A) m_newline();
    else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_mem[m_row*32 + m_col] = 8'h20;
        exp_w++;
      end
    end else begin
      exp_mem[m_row*32 + m_col] = c;
      exp_w++;
      m_col++;
      if (m_col == COLS) m_newline();
    end
  endtask

  task automatic send_ch(input logic [7:0] c);
    int n = 0;
    ch_data  = c;
    ch_valid = 1'b1;
    #1;
    while (ch_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_50mhz); #1; n++;
    end
    chk("accept_bound", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk_50mhz);
    ch_valid = 1'b0;
    w_we = vm_we; w_addr = vm_addr; w_din = vm_din;
    m_char(c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || vm_we !== 1'b0) && n < 3000) begin
      @(negedge clk_50mhz); n++;
    end
    chk("idle_bound", (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk_50mhz);
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, 32'(cur_row), 32'(m_row));
    chk({tag, "_col"}, 32'(cur_col), 32'(m_col));
  endtask

  task automatic mem_cmp(input string tag);
    int nb = 0;
    for (int a = 0; a < 4096; a++) if (shadow[a] !== exp_mem[a]) nb++;
    chk(tag, 32'(nb), 32'd0);
    chk({tag, "_wcount"}, 32'(wr_cnt), 32'(exp_w));
  endtask

  initial begin
    int n, k, base, ord_bad, drop, guard;
    logic [7:0] c;
    for (int a = 0; a < 4096; a++) begin shadow[a] = 8'h00; exp_mem[a] = 8'h00; end
    rst = 1'b1; rst2 = 1'b1;
    ch_valid = 1'b0; ch_data = 8'h00; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    clr_req = 1'b0; m_row = 0; m_col = 0; exp_w = 0;
    repeat (3) @(negedge clk_50mhz);

    // Reset state
    ch_valid = 1'b1; #1;
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    ch_valid = 1'b0;
    chk("rst_vm_we", 32'(vm_we), 32'd0);
    chk("rst_vm_addr", 32'(vm_addr), 32'd0);
    chk("rst_vm_din", 32'(vm_din), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_cursor("rst");
    @(negedge clk_50mhz);
    rst = 1'b0;
    @(negedge clk_50mhz);
    chk("idle_ready", 32'(ch_ready), 32'd1);

    // First printable lands at (0,0)
    send_ch(8'h41);
    chk("t1_we", 32'(w_we), 32'd1);
    chk("t1_addr", 32'(w_addr), 32'h000);
    chk("t1_din", 32'(w_din), 32'h41);
    chk_cursor("t1");
    wait_idle();

    // A full row wraps into a line clear of row 1
    send_ch(8'h0D);
    for (int i = 0; i < 32; i++) send_ch(8'(8'h30 + i));
    chk("t2_last_addr", 32'(w_addr), 32'h01F);
    chk("t2_last_din", 32'(w_din), 32'h4F);
    chk_cursor("t2");
    n = 0;
    while (ch_ready !== 1'b1 && n < 100) begin @(negedge clk_50mhz); n++; end
    chk("t2_ready_low", 32'(n), 32'd32);
    wait_idle();
    mem_cmp("t2_mem");

    // Random console stream
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 11))
        0: c = 8'h0A;
        1: c = 8'h0D;
        2: c = 8'h08;
        default: begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h0A || c == 8'h0D || c == 8'h08) c = 8'h7F;
        end
      endcase
      send_ch(c);
      chk_cursor("rnd");
    end
    wait_idle();
    mem_cmp("rnd_mem");

    // Newline on the last row wraps to row 0 and blanks it
    send_ch(8'h0D);
    guard = 0;
    while (m_row != 29 && guard < 40) begin send_ch(8'h0A); guard++; end
    for (int i = 0; i < 5; i++) send_ch(8'h61);
    chk("t3_pre_row", 32'(cur_row), 32'd29);
    chk("t3_pre_col", 32'(cur_col), 32'd5);
    wait_idle();
    base = wr_cnt;
    send_ch(8'h0A);
    chk("t3_row", 32'(cur_row), 32'd0);
    chk("t3_col", 32'(cur_col), 32'd0);
    wait_idle();
    chk("t3_writes", 32'(wr_cnt - base), 32'd32);
    n = 0;
    for (int a = 0; a < 32; a++) if (shadow[a] === 8'h20) n++;
    chk("t3_row0_blank", 32'(n), 32'd32);

    // Simultaneous CPU and console requests
    cpu_we = 1'b1; cpu_addr = 12'h3FF; cpu_din = 8'h7E;
    ch_valid = 1'b1; ch_data = 8'h42;
    #1;
    chk("t5_ready_blocked", 32'(ch_ready), 32'd0);
    @(negedge clk_50mhz);
    chk("t5_cpu_we", 32'(vm_we), 32'd1);
    chk("t5_cpu_addr", 32'(vm_addr), 32'h3FF);
    chk("t5_cpu_din", 32'(vm_din), 32'h7E);
    chk("t5_cpu_ack", 32'(cpu_ack), 32'd1);
    chk_cursor("t5_hold");
    cpu_we = 1'b0;
    #1;
    chk("t5_ready_after", 32'(ch_ready), 32'd1);
    @(negedge clk_50mhz);
    ch_valid = 1'b0;
    chk("t5_ch_we", 32'(vm_we), 32'd1);
    chk("t5_ch_addr", 32'(vm_addr), 32'(m_row*32 + m_col));
    chk("t5_ch_din", 32'(vm_din), 32'h42);
    chk("t5_ack_gone", 32'(cpu_ack), 32'd0);
    exp_mem[12'h3FF] = 8'h7E; exp_w++;
    m_char(8'h42);
    chk_cursor("t5");
    wait_idle();

    // Full-screen clear, with a redundant pulse mid-sweep
    base = wr_cnt;
    clr_req = 1'b1;
    @(negedge clk_50mhz);
    clr_req = 1'b0;
    k = 0; ord_bad = 0; drop = 0; n = 0;
    while (k < 960 && n < 2000) begin
      @(negedge clk_50mhz); n++;
      clr_req = (n == 300);
      if (busy !== 1'b1 && !(vm_we === 1'b1 && k == 959)) drop++;
      if (vm_we === 1'b1) begin
        if (vm_addr !== 12'(k) || vm_din !== 8'h20) ord_bad++;
        k++;
      end
    end
    clr_req = 1'b0;
    chk("t4_count", 32'(k), 32'd960);
    chk("t4_order", 32'(ord_bad), 32'd0);
    chk("t4_busy_drop", 32'(drop), 32'd0);
    repeat (40) @(negedge clk_50mhz);
    chk("t4_total_writes", 32'(wr_cnt - base), 32'd960);
    chk("t4_busy_after", 32'(busy), 32'd0);
    for (int a = 0; a < 960; a++) exp_mem[a] = 8'h20;
    exp_w += 960; m_row = 0; m_col = 0;
    chk_cursor("t4");
    mem_cmp("t4_mem");

    // Backspace at column 0 and mid-line
    base = wr_cnt;
    send_ch(8'h08);
    chk("t6_bs0_we", 32'(w_we), 32'd0);
    wait_idle();
    chk("t6_bs0_writes", 32'(wr_cnt - base), 32'd0);
    chk_cursor("t6_bs0");
    send_ch(8'h0A); send_ch(8'h0A);
    send_ch(8'h61); send_ch(8'h62); send_ch(8'h63);
    chk("t6_pre_row", 32'(cur_row), 32'd2);
    chk("t6_pre_col", 32'(cur_col), 32'd3);
    send_ch(8'h08);
    chk("t6_bs_we", 32'(w_we), 32'd1);
    chk("t6_bs_addr", 32'(w_addr), 32'h042);
    chk("t6_bs_din", 32'(w_din), 32'h20);
    chk("t6_row", 32'(cur_row), 32'd2);
    chk("t6_col", 32'(cur_col), 32'd2);
    wait_idle();
    mem_cmp("t6_mem");

    // Reset in the middle of a full clear
    clr_req = 1'b1;
    @(negedge clk_50mhz);
    clr_req = 1'b0;
    k = 0; n = 0;
    while (k < 100 && n < 500) begin
      @(negedge clk_50mhz); n++;
      if (vm_we === 1'b1) k++;
    end
    chk("t7_reached", 32'(k), 32'd100);
    rst = 1'b1;
    #1;
    chk("t7_we_cut", 32'(vm_we), 32'd0);
    chk("t7_busy_cut", 32'(busy), 32'd0);
    chk("t7_ready_cut", 32'(ch_ready), 32'd0);
    repeat (2) @(negedge clk_50mhz);
    rst = 1'b0;
    base = wr_cnt;
    repeat (20) @(negedge clk_50mhz);
    chk("t7_no_resume", 32'(wr_cnt - base), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_row", 32'(cur_row), 32'd0);
    chk("t7_col", 32'(cur_col), 32'd0);
    chk("t7_ready", 32'(ch_ready), 32'd1);

    // Clear-on-reset variant
    chk("cor_rst_we", 32'(vm_we2), 32'd0);
    chk("cor_rst_busy", 32'(busy2), 32'd0);
    rst2 = 1'b0;
    base = wr_cnt2;
    @(negedge clk_50mhz);
    chk("cor_busy_start", 32'(busy2), 32'd1);
    n = 0;
    while ((busy2 !== 1'b0 || vm_we2 !== 1'b0) && n < 1100) begin
      @(negedge clk_50mhz); n++;
    end
    repeat (2) @(negedge clk_50mhz);
    chk("cor_writes", 32'(wr_cnt2 - base), 32'd960);
    chk("cor_row", 32'(cur_row2), 32'd0);
    chk("cor_col", 32'(cur_col2), 32'd0);
    chk("cor_ready", 32'(ch_ready2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
